csr_wport_arb: RTL and testbench

Write-port arbiter and sequencer for the single-write-port machine CSR file. It merges the one-cycle trap/MRET write pulses from the core-local interruptor (up to three CSRs in the same cycle) with CSR-instruction writes from the execute stage. It serializes them onto one write port, one CSR per cycle, with trap writes strictly ahead of instruction writes. It sits between the interruptor, the EXU and the CSR register file, and stalls the EXU through a valid/ready handshake.

---
 rtl/csr_wport_arb.sv | 70 +++++++
 tb/tb_csr_wport_arb.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/csr_wport_arb.sv
// csr_wport_arb: serializes trap/MRET CSR write pulses and EXU CSR writes onto one registered write port
module csr_wport_arb #(
  parameter int          XLEN         = 64,
  parameter logic [11:0] ADDR_MEPC    = 12'h341,
  parameter logic [11:0] ADDR_MCAUSE  = 12'h342,
  parameter logic [11:0] ADDR_MSTATUS = 12'h300
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clint_mepc_wen_i,
  input  logic [XLEN-1:0] clint_mepc_wdata_i,
  input  logic            clint_mcause_wen_i,
  input  logic [XLEN-1:0] clint_mcause_wdata_i,
  input  logic            clint_mstatus_wen_i,
  input  logic [XLEN-1:0] clint_mstatus_wdata_i,
  input  logic            exu_csr_valid_i,
  input  logic [11:0]     exu_csr_waddr_i,
  input  logic [XLEN-1:0] exu_csr_wdata_i,
  output logic            exu_csr_ready_o,
  output logic            csr_wen_o,
  output logic [11:0]     csr_waddr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            arb_busy_o
);
  logic            pend_mepc, pend_mcause, pend_mstatus;
  logic [XLEN-1:0] mepc_q, mcause_q, mstatus_q;
  logic            any_wen, sel_mepc, sel_mcause, sel_mstatus, sel_exu;
  assign any_wen         = clint_mepc_wen_i | clint_mcause_wen_i | clint_mstatus_wen_i;
  assign arb_busy_o      = pend_mepc | pend_mcause | pend_mstatus | any_wen;
  assign exu_csr_ready_o = rst_n & ~pend_mepc & ~pend_mcause & ~pend_mstatus & ~any_wen;
  assign sel_mepc        = pend_mepc;
  assign sel_mcause      = ~pend_mepc & pend_mcause;
  assign sel_mstatus     = ~pend_mepc & ~pend_mcause & pend_mstatus;
  assign sel_exu         = exu_csr_valid_i & exu_csr_ready_o;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_mepc    <= 1'b0;
      pend_mcause  <= 1'b0;
      pend_mstatus <= 1'b0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mstatus_q    <= '0;
      csr_wen_o    <= 1'b0;
      csr_waddr_o  <= '0;
      csr_wdata_o  <= '0;
    end else begin
      // a new pulse for the CSR being drained keeps its flag set
      pend_mepc    <= clint_mepc_wen_i    | (pend_mepc    & ~sel_mepc);
      pend_mcause  <= clint_mcause_wen_i  | (pend_mcause  & ~sel_mcause);
      pend_mstatus <= clint_mstatus_wen_i | (pend_mstatus & ~sel_mstatus);
      if (clint_mepc_wen_i)    mepc_q    <= clint_mepc_wdata_i;
      if (clint_mcause_wen_i)  mcause_q  <= clint_mcause_wdata_i;
      if (clint_mstatus_wen_i) mstatus_q <= clint_mstatus_wdata_i;
      csr_wen_o <= sel_mepc | sel_mcause | sel_mstatus | sel_exu;
      if (sel_mepc) begin
        csr_waddr_o <= ADDR_MEPC;
        csr_wdata_o <= mepc_q;
      end else if (sel_mcause) begin
        csr_waddr_o <= ADDR_MCAUSE;
        csr_wdata_o <= mcause_q;
      end else if (sel_mstatus) begin
        csr_waddr_o <= ADDR_MSTATUS;
        csr_wdata_o <= mstatus_q;
      end else if (sel_exu) begin
        csr_waddr_o <= exu_csr_waddr_i;
        csr_wdata_o <= exu_csr_wdata_i;
      end
    end
  end
endmodule

// File: tb/tb_csr_wport_arb.sv
// tb_csr_wport_arb: random and directed stimulus checked against a cycle-level pending-set reference model
module tb_csr_wport_arb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mepc_wen, mcause_wen, mstatus_wen;
  logic [63:0] mepc_wd, mcause_wd, mstatus_wd;
  logic        exu_valid;
  logic [11:0] exu_addr;
  logic [63:0] exu_data;
  logic        exu_ready, csr_wen, busy;
  logic [11:0] csr_waddr;
  logic [63:0] csr_wdata;
  csr_wport_arb dut (
    .clk(clk), .rst_n(rst_n),
    .clint_mepc_wen_i(mepc_wen), .clint_mepc_wdata_i(mepc_wd),
    .clint_mcause_wen_i(mcause_wen), .clint_mcause_wdata_i(mcause_wd),
    .clint_mstatus_wen_i(mstatus_wen), .clint_mstatus_wdata_i(mstatus_wd),
    .exu_csr_valid_i(exu_valid), .exu_csr_waddr_i(exu_addr), .exu_csr_wdata_i(exu_data),
    .exu_csr_ready_o(exu_ready), .csr_wen_o(csr_wen), .csr_waddr_o(csr_waddr),
    .csr_wdata_o(csr_wdata), .arb_busy_o(busy)
  );
  always #5 clk = ~clk;
  int vecs = 0, errs = 0;
  logic [2:0]  mp;
  logic [63:0] mdat [3];
  logic        mw;
  logic [11:0] ma;
  logic [63:0] md;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [11:0] trap_addr(input int i);
    return i == 0 ? 12'h341 : i == 1 ? 12'h342 : 12'h300;
  endfunction
  // one clock cycle: inputs applied just after an edge, checks before and after the next edge
  task automatic cyc(input logic r, input logic [2:0] w, input logic [63:0] d0, input logic [63:0] d1,
                     input logic [63:0] d2, input logic v, input logic [11:0] a, input logic [63:0] d,
                     output logic acc);
    logic e_rdy;
    int k;
    logic [63:0] dd [3];
    dd[0] = d0; dd[1] = d1; dd[2] = d2;
    rst_n = r;
    {mstatus_wen, mcause_wen, mepc_wen} = w;
    mepc_wd = d0; mcause_wd = d1; mstatus_wd = d2;
    exu_valid = v; exu_addr = a; exu_data = d;
    e_rdy = r && mp == 3'b0 && w == 3'b0;
    acc = v && e_rdy;
    #3;
    check("ready", {63'b0, exu_ready}, {63'b0, e_rdy});
    check("busy", {63'b0, busy}, {63'b0, (mp != 3'b0) || (w != 3'b0)});
    @(posedge clk);
    #1;
    if (!r) begin
      mp = 3'b0;
      for (int i = 0; i < 3; i++) mdat[i] = '0;
      mw = 1'b0; ma = '0; md = '0;
    end else begin
      k = -1;
      for (int i = 2; i >= 0; i--) if (mp[i]) k = i;
      if (k >= 0) begin
        mw = 1'b1; ma = trap_addr(k); md = mdat[k]; mp[k] = 1'b0;
      end else if (acc) begin
        mw = 1'b1; ma = a; md = d;
      end else mw = 1'b0;
      for (int i = 0; i < 3; i++) if (w[i]) begin
        mp[i] = 1'b1; mdat[i] = dd[i];
      end
    end
    check("csr_wen", {63'b0, csr_wen}, {63'b0, mw});
    check("csr_waddr", {52'b0, csr_waddr}, {52'b0, ma});
    check("csr_wdata", csr_wdata, md);
  endtask
  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cyc(1'b1, 3'b000, '0, '0, '0, 1'b0, '0, '0, acc);
  endtask
  logic        acc, hv;
  logic [11:0] ha;
  logic [63:0] hd;
  logic [2:0]  rw;
  int          exp_acc;
  initial begin
    rst_n = 1'b0; {mepc_wen, mcause_wen, mstatus_wen} = 3'b0;
    mepc_wd = '0; mcause_wd = '0; mstatus_wd = '0;
    exu_valid = 1'b0; exu_addr = '0; exu_data = '0;
    mp = 3'b0; mw = 1'b0; ma = '0; md = '0;
    for (int i = 0; i < 3; i++) mdat[i] = '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
          1'($urandom), 12'($urandom), {$urandom, $urandom}, acc);
    check("rst_wen", {63'b0, csr_wen}, 64'd0);
    check("rst_wdata", csr_wdata, 64'd0);
    idle(1);
    // trap triple
    cyc(1'b1, 3'b111, 64'h8000_0010, 64'd11, 64'h1800, 1'b0, '0, '0, acc);
    idle(1);
    check("tri_mepc_addr", {52'b0, csr_waddr}, 64'h341);
    check("tri_mepc_data", csr_wdata, 64'h8000_0010);
    idle(1);
    check("tri_mcause_data", csr_wdata, 64'd11);
    idle(1);
    check("tri_mstatus_addr", {52'b0, csr_waddr}, 64'h300);
    idle(2);
    check("tri_done_wen", {63'b0, csr_wen}, 64'd0);
    // MRET
    cyc(1'b1, 3'b100, '0, '0, 64'h88, 1'b0, '0, '0, acc);
    idle(1);
    check("mret_data", csr_wdata, 64'h88);
    idle(2);
    // EXU alone then back-to-back
    cyc(1'b1, 3'b000, '0, '0, '0, 1'b1, 12'h305, 64'h8000_0000, acc);
    check("exu_acc", {63'b0, acc}, 64'd1);
    check("exu_addr", {52'b0, csr_waddr}, 64'h305);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 3'b000, '0, '0, '0, 1'b1, 12'h340 + 12'(i), 64'(i) + 64'h100, acc);
      check("b2b_wen", {63'b0, csr_wen}, 64'd1);
    end
    idle(1);
    // collision: EXU held through a trap triple
    cyc(1'b1, 3'b111, 64'h1, 64'h2, 64'h3, 1'b1, 12'h341, 64'hDEAD, acc);
    exp_acc = 0;
    while (!acc && exp_acc < 10) begin
      cyc(1'b1, 3'b000, '0, '0, '0, 1'b1, 12'h341, 64'hDEAD, acc);
      exp_acc++;
    end
    check("coll_accept_cycle", 64'(exp_acc), 64'd4);
    check("coll_data", csr_wdata, 64'hDEAD);
    idle(1);
    // overwrite of mepc in its selection cycle
    cyc(1'b1, 3'b111, 64'h10, 64'h5, 64'h6, 1'b0, '0, '0, acc);
    cyc(1'b1, 3'b001, 64'h20, '0, '0, 1'b0, '0, '0, acc);
    check("ovw_first", csr_wdata, 64'h10);
    idle(1);
    check("ovw_second", csr_wdata, 64'h20);
    idle(3);
    // reset mid-drain
    cyc(1'b1, 3'b111, 64'hA, 64'hB, 64'hC, 1'b0, '0, '0, acc);
    idle(1);
    cyc(1'b0, 3'b000, '0, '0, '0, 1'b0, '0, '0, acc);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("rst_drain_wen", {63'b0, csr_wen}, 64'd0);
    end
    // random traffic with the EXU request held until accepted
    hv = 1'b0; ha = '0; hd = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!hv && $urandom_range(0, 2) == 0) begin
        hv = 1'b1; ha = 12'($urandom); hd = {$urandom, $urandom};
      end
      rw = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
      cyc($urandom_range(0, 99) != 0, rw, {$urandom, $urandom}, {$urandom, $urandom},
          {$urandom, $urandom}, hv, ha, hd, acc);
      if (acc) hv = 1'b0;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
